// File: rtl/midi_voice_alloc_pkg.sv
// Shared types and constants for the MIDI voice allocator: voice slot record,
// allocator FSM states and a saturating age increment helper.
package midi_voice_alloc_pkg;

    localparam int MIDI_NOTE_W = 7;
    localparam int MIDI_CH_W   = 4;

    // Storage width of the age field; the top-level AGE_W (<= 16) sets the
    // actual saturation point, so the upper bits simply stay zero.
    localparam int AGE_FIELD_W = 16;

    typedef struct packed {
        logic [MIDI_NOTE_W-1:0] note;
        logic [MIDI_NOTE_W-1:0] vel;
        logic [MIDI_CH_W-1:0]   ch;
        logic [AGE_FIELD_W-1:0] age;
    } voice_t;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        UPDATE
    } alloc_state_t;

    // Age one step older, holding at age_max once reached.
    function automatic logic [AGE_FIELD_W-1:0] age_inc(
        input logic [AGE_FIELD_W-1:0] age,
        input logic [AGE_FIELD_W-1:0] age_max
    );
        return (age >= age_max) ? age : age + 1'b1;
    endfunction

endpackage

// File: rtl/midi_voice_alloc_if.sv
// Decoded MIDI event bus from the receiver into the voice allocator.
// master = event source (receiver), slave = allocator.
interface midi_voice_alloc_if;
    import midi_voice_alloc_pkg::*;

    logic                   rdy_out;   // 1-cycle strobe, event fields valid
    logic                   note_on;
    logic                   note_off;
    logic                   error;     // frame error, event must be ignored
    logic [MIDI_CH_W-1:0]   ch;
    logic [MIDI_NOTE_W-1:0] D1;        // note number
    logic [MIDI_NOTE_W-1:0] D2;        // velocity

    modport master (
        output rdy_out, note_on, note_off, error, ch, D1, D2
    );

    modport slave (
        input rdy_out, note_on, note_off, error, ch, D1, D2
    );

endinterface

// File: rtl/midi_voice_alloc_search.sv
// Combinational slot search for the voice allocator: finds the lowest gated
// slot holding (key_ch, key_note), the lowest ungated slot, and the oldest
// gated slot (ties resolved toward the lowest index).
module midi_voice_alloc_search
    import midi_voice_alloc_pkg::*;
#(
    parameter int NVOICES = 8,
    parameter int IDX_W   = 3
) (
    input  voice_t [NVOICES-1:0]   slots,
    input  logic   [NVOICES-1:0]   gate,
    input  logic [MIDI_CH_W-1:0]   key_ch,
    input  logic [MIDI_NOTE_W-1:0] key_note,
    output logic                   match_hit,
    output logic [IDX_W-1:0]       match_idx,
    output logic                   free_hit,
    output logic [IDX_W-1:0]       free_idx,
    output logic [IDX_W-1:0]       oldest_idx
);

    logic                   oldest_found;
    logic [AGE_FIELD_W-1:0] oldest_age;

    // Match and free search: scan downward so the lowest qualifying index wins.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment so no path leaves it unassigned (no latch).
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = NVOICES - 1; i >= 0; i--) begin
            if (gate[i] && (slots[i].ch == key_ch) && (slots[i].note == key_note)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!gate[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Oldest search: scan upward, replace only on strictly greater age so ties keep the lower index.
    always_comb begin
        oldest_found = 1'b0;
        oldest_age   = '0;
        oldest_idx   = '0;
        for (int i = 0; i < NVOICES; i++) begin
            if (gate[i] && (!oldest_found || (slots[i].age > oldest_age))) begin
                oldest_found = 1'b1;
                oldest_age   = slots[i].age;
                oldest_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator. Accepts decoded Note On/Off events and maps
// them onto NVOICES synth voice slots: same-note retrigger first, then the
// lowest free slot, otherwise the oldest held voice is stolen.
// Each event takes IDLE -> LOOKUP -> UPDATE; events arriving while busy are
// dropped and counted.
module midi_voice_alloc
    import midi_voice_alloc_pkg::*;
#(
    parameter int NVOICES = 8,
    parameter int AGE_W   = 4,
    parameter int DROP_W  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    midi_voice_alloc_if.slave              evt,
    input  logic [15:0]                    ch_mask,
    output logic [NVOICES-1:0]             voice_gate,
    output logic [NVOICES-1:0]             voice_trig,
    output logic [NVOICES*MIDI_NOTE_W-1:0] voice_note,
    output logic [NVOICES*MIDI_NOTE_W-1:0] voice_vel,
    output logic [NVOICES*MIDI_CH_W-1:0]   voice_ch,
    output logic                           busy,
    output logic [DROP_W-1:0]              drop_cnt
);

    localparam int IDX_W = (NVOICES > 1) ? $clog2(NVOICES) : 1;
    localparam logic [AGE_FIELD_W-1:0] AGE_MAX = AGE_FIELD_W'((1 << AGE_W) - 1);

    alloc_state_t           state;

    // Latched event
    logic [MIDI_CH_W-1:0]   lat_ch;
    logic [MIDI_NOTE_W-1:0] lat_note;
    logic [MIDI_NOTE_W-1:0] lat_vel;
    logic                   lat_on;

    // Slot storage
    voice_t [NVOICES-1:0]   slots;

    // Combinational search results on the latched event
    logic                   s_match_hit;
    logic [IDX_W-1:0]       s_match_idx;
    logic                   s_free_hit;
    logic [IDX_W-1:0]       s_free_idx;
    logic [IDX_W-1:0]       s_oldest_idx;

    // Search results registered in LOOKUP, consumed in UPDATE
    logic                   match_hit_q;
    logic [IDX_W-1:0]       match_idx_q;
    logic [IDX_W-1:0]       target_q;

    logic                   accept;

    // An event is taken only when exactly one of note_on/note_off is set on an enabled channel.
    assign accept = evt.rdy_out && !evt.error && ch_mask[evt.ch] &&
                    (evt.note_on ^ evt.note_off);

    midi_voice_alloc_search #(
        .NVOICES (NVOICES),
        .IDX_W   (IDX_W)
    ) u_search (
        .slots      (slots),
        .gate       (voice_gate),
        .key_ch     (lat_ch),
        .key_note   (lat_note),
        .match_hit  (s_match_hit),
        .match_idx  (s_match_idx),
        .free_hit   (s_free_hit),
        .free_idx   (s_free_idx),
        .oldest_idx (s_oldest_idx)
    );

    // Allocator FSM: latch the event, register the search, then hand off to the slot update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            lat_ch      <= '0;
            lat_note    <= '0;
            lat_vel     <= '0;
            lat_on      <= 1'b0;
            match_hit_q <= 1'b0;
            match_idx_q <= '0;
            target_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_ch   <= evt.ch;
                        lat_note <= evt.D1;
                        lat_vel  <= evt.D2;
                        // Zero-velocity Note On is a Note Off in MIDI running practice.
                        lat_on   <= evt.note_on && (evt.D2 != '0);
                        state    <= LOOKUP;
                        busy     <= 1'b1;
                    end
                end
                LOOKUP: begin
                    match_hit_q <= s_match_hit;
                    match_idx_q <= s_match_idx;
                    target_q    <= s_match_hit ? s_match_idx :
                                   s_free_hit  ? s_free_idx  : s_oldest_idx;
                    state       <= UPDATE;
                end
                UPDATE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Slot update in UPDATE: allocate/retrigger on Note On, release the matching slot on Note Off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the slot array is a handful of flops driving outputs that
            // must read zero after reset, so it is cleared like any register.
            slots      <= '0;
            voice_gate <= '0;
            voice_trig <= '0;
        end else begin
            voice_trig <= '0;
            if (state == UPDATE) begin
                if (lat_on) begin
                    for (int i = 0; i < NVOICES; i++) begin
                        if (voice_gate[i] && (IDX_W'(i) != target_q)) begin
                            slots[i].age <= age_inc(slots[i].age, AGE_MAX);
                        end
                    end
                    slots[target_q].note <= lat_note;
                    slots[target_q].vel  <= lat_vel;
                    slots[target_q].ch   <= lat_ch;
                    slots[target_q].age  <= '0;
                    voice_gate[target_q] <= 1'b1;
                    voice_trig[target_q] <= 1'b1;
                end else if (match_hit_q) begin
                    voice_gate[match_idx_q] <= 1'b0;
                end
            end
        end
    end

    // Count events that arrive while an earlier one is still being processed; hold at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (evt.rdy_out && (state != IDLE) && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Flatten slot fields onto the packed per-voice output buses.
    always_comb begin
        voice_note = '0;
        voice_vel  = '0;
        voice_ch   = '0;
        for (int k = 0; k < NVOICES; k++) begin
            voice_note[k*MIDI_NOTE_W +: MIDI_NOTE_W] = slots[k].note;
            voice_vel [k*MIDI_NOTE_W +: MIDI_NOTE_W] = slots[k].vel;
            voice_ch  [k*MIDI_CH_W   +: MIDI_CH_W]   = slots[k].ch;
        end
    end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Scoreboard bench for midi_voice_alloc: directed scenarios plus random
// Note On/Off traffic against a slot-level reference model.
module tb_midi_voice_alloc;
    import midi_voice_alloc_pkg::*;

    localparam int NV       = 8;
    localparam int AGE_MAX  = 15;
    localparam int DROP_MAX = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       ch_mask;
    logic [NV-1:0]     voice_gate;
    logic [NV-1:0]     voice_trig;
    logic [NV*7-1:0]   voice_note;
    logic [NV*7-1:0]   voice_vel;
    logic [NV*4-1:0]   voice_ch;
    logic              busy;
    logic [7:0]        drop_cnt;

    midi_voice_alloc_if bus();

    midi_voice_alloc #(
        .NVOICES (NV),
        .AGE_W   (4),
        .DROP_W  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .evt        (bus),
        .ch_mask    (ch_mask),
        .voice_gate (voice_gate),
        .voice_trig (voice_trig),
        .voice_note (voice_note),
        .voice_vel  (voice_vel),
        .voice_ch   (voice_ch),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_gate [NV];
    int m_note [NV];
    int m_vel  [NV];
    int m_ch   [NV];
    int m_age  [NV];
    int m_drop;

    typedef struct {
        logic [NV-1:0]   gate;
        logic [NV-1:0]   trig;
        logic [NV*7-1:0] note;
        logic [NV*7-1:0] vel;
        logic [NV*4-1:0] ch;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];

    function automatic int sat_drop();
        return (m_drop > DROP_MAX) ? DROP_MAX : m_drop;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_ch[i] = 0; m_age[i] = 0;
        end
        m_drop = 0;
    endtask

    // Apply one accepted event; returns which slot (if any) gets a trigger.
    task automatic model_apply(input bit on, input int c, input int n, input int v,
                               output logic [NV-1:0] trig);
        int hit, fr, tgt, best;
        trig = '0;
        hit = -1; fr = -1; tgt = -1; best = -1;
        for (int i = 0; i < NV; i++)
            if (hit < 0 && m_gate[i] != 0 && m_ch[i] == c && m_note[i] == n) hit = i;
        if (on && v != 0) begin
            for (int i = 0; i < NV; i++)
                if (fr < 0 && m_gate[i] == 0) fr = i;
            if (hit >= 0) tgt = hit;
            else if (fr >= 0) tgt = fr;
            else begin
                for (int i = 0; i < NV; i++)
                    if (m_age[i] > best) begin best = m_age[i]; tgt = i; end
            end
            for (int i = 0; i < NV; i++)
                if (i != tgt && m_gate[i] != 0 && m_age[i] < AGE_MAX) m_age[i]++;
            m_gate[tgt] = 1; m_note[tgt] = n; m_vel[tgt] = v; m_ch[tgt] = c; m_age[tgt] = 0;
            trig[tgt] = 1'b1;
        end else if (hit >= 0) begin
            m_gate[hit] = 0;
        end
    endtask

    task automatic push_exp(input logic [NV-1:0] trig, input int issue);
        exp_t e;
        e.trig = trig;
        e.cyc  = issue;
        for (int i = 0; i < NV; i++) begin
            e.gate[i]       = (m_gate[i] != 0);
            e.note[7*i +: 7] = 7'(m_note[i]);
            e.vel [7*i +: 7] = 7'(m_vel[i]);
            e.ch  [4*i +: 4] = 4'(m_ch[i]);
        end
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit   prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
                continue;
            end
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_completion: got event completion, want none pending");
                end else begin
                    e = exp_q.pop_front();
                    check("latency", 64'(cyc), 64'(e.cyc + 3));
                    check("gate", 64'(voice_gate), 64'(e.gate));
                    check("trig", 64'(voice_trig), 64'(e.trig));
                    check("note", 64'(voice_note), 64'(e.note));
                    check("vel",  64'(voice_vel),  64'(e.vel));
                    check("ch",   64'(voice_ch),   64'(e.ch));
                end
            end else begin
                check("trig_idle", 64'(voice_trig), 64'd0);
            end
            prev_busy = busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit on, input bit off, input bit err, input int c, input int n, input int v);
        bus.rdy_out  = 1'b1;
        bus.note_on  = on;
        bus.note_off = off;
        bus.error    = err;
        bus.ch       = 4'(c);
        bus.D1       = 7'(n);
        bus.D2       = 7'(v);
    endtask

    // One event; returns one edge before its completion edge so the next call lands in IDLE.
    task automatic send(input bit on, input bit off, input bit err, input int c, input int n, input int v);
        bit            acc;
        logic [NV-1:0] tr;
        acc = !err && ch_mask[c] && (on ^ off);
        @(posedge clk); #2;
        drive(on, off, err, c, n, v);
        if (acc) begin
            model_apply(on, c, n, v, tr);
            push_exp(tr, cyc);
        end
        @(posedge clk); #2;
        bus.rdy_out = 1'b0;
        if (!acc) begin
            check("ignored_busy", 64'(busy), 64'd0);
            check("ignored_drop", 64'(drop_cnt), 64'(sat_drop()));
        end
        @(posedge clk);
    endtask

    task automatic settle();
        @(posedge clk); #2;
    endtask

    initial begin
        logic [NV-1:0] tr;
        bit on, off, err;
        int sel, v;

        bus.rdy_out = 1'b0; bus.note_on = 1'b0; bus.note_off = 1'b0; bus.error = 1'b0;
        bus.ch = '0; bus.D1 = '0; bus.D2 = '0;
        ch_mask = 16'hffff;
        model_reset();

        // 1: reset state, then first allocation
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        check("rst_gate", 64'(voice_gate), 64'd0);
        check("rst_trig", 64'(voice_trig), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_note", 64'(voice_note), 64'd0);

        send(1, 0, 0, 3, 26, 34);
        settle();
        check("t1_gate", 64'(voice_gate), 64'h01);
        check("t1_note0", 64'(voice_note[6:0]), 64'd26);
        check("t1_vel0", 64'(voice_vel[6:0]), 64'd34);
        check("t1_ch0", 64'(voice_ch[3:0]), 64'd3);

        // 2: retrigger, release, unmatched release
        send(1, 0, 0, 3, 26, 90);
        settle();
        check("t2_vel0", 64'(voice_vel[6:0]), 64'd90);
        check("t2_gate", 64'(voice_gate), 64'h01);
        send(0, 1, 0, 3, 26, 0);
        settle();
        check("t2_off_gate", 64'(voice_gate), 64'h00);
        send(0, 1, 0, 8, 100, 10);

        // 3: fill all slots, then steal oldest twice
        for (int n = 60; n < 68; n++) send(1, 0, 0, 0, n, 100);
        settle();
        check("t3_full", 64'(voice_gate), 64'hff);
        send(1, 0, 0, 0, 70, 100);
        settle();
        check("t3_steal0", 64'(voice_note[6:0]), 64'd70);
        send(1, 0, 0, 0, 71, 100);
        settle();
        check("t3_steal1", 64'(voice_note[13:7]), 64'd71);

        // 4: zero-velocity Note On, masked channel, frame error, both flags
        send(1, 0, 0, 12, 12, 0);
        ch_mask = 16'hffdf;
        send(1, 0, 0, 5, 40, 64);
        ch_mask = 16'hffff;
        send(1, 0, 1, 2, 41, 64);
        send(1, 1, 0, 2, 42, 64);

        // 5: drop while busy, then saturate the drop counter
        @(posedge clk); #2;
        drive(1, 0, 0, 1, 30, 50);
        model_apply(1, 1, 30, 50, tr);
        push_exp(tr, cyc);
        @(posedge clk); #2;
        drive(1, 0, 0, 1, 31, 50);
        m_drop++;
        @(posedge clk); #2;
        bus.rdy_out = 1'b0;
        settle();
        check("t5_drop1", 64'(drop_cnt), 64'd1);

        for (int c = 0; c < 450; c++) begin
            @(posedge clk); #2;
            drive(0, 1, 0, 8, 100, 5);
            if (c % 3 == 0) begin
                model_apply(0, 8, 100, 5, tr);
                push_exp(tr, cyc);
            end else begin
                m_drop++;
            end
        end
        @(posedge clk); #2;
        bus.rdy_out = 1'b0;
        repeat (3) settle();
        check("t5_drop_sat", 64'(drop_cnt), 64'(sat_drop()));

        // 6: reset during LOOKUP aborts the event
        @(posedge clk); #2;
        drive(1, 0, 0, 1, 40, 50);
        @(posedge clk); #2;
        bus.rdy_out = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        model_reset();
        check("t6_gate", 64'(voice_gate), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_trig", 64'(voice_trig), 64'd0);
        check("t6_drop", 64'(drop_cnt), 64'd0);
        send(1, 0, 0, 9, 77, 33);
        settle();
        check("t6_slot0", 64'(voice_gate), 64'h01);
        check("t6_note0", 64'(voice_note[6:0]), 64'd77);

        // 7: random traffic
        for (int r = 0; r < 300; r++) begin
            ch_mask = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'hffff;
            err = ($urandom_range(0, 15) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)      begin on = 1; off = 0; end
            else if (sel < 9) begin on = 0; off = 1; end
            else              begin on = 1'($urandom); off = on; end
            v = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
            send(on, off, err, $urandom_range(0, 3), $urandom_range(60, 67), v);
        end
        ch_mask = 16'hffff;

        repeat (5) settle();
        check("pending", 64'(exp_q.size()), 64'd0);
        check("final_drop", 64'(drop_cnt), 64'(sat_drop()));
        check("final_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
